// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM candidate selector.
package esm_pkg;

  typedef enum logic [1:0] {
    RANDOM      = 2'd0,
    ROUND_ROBIN = 2'd1,
    LOWEST      = 2'd2
  } sel_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUILD  = 2'd1,
    SELECT = 2'd2,
    OUT    = 2'd3
  } state_t;

  // Right-shift Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/esm_lfsr.sv
// Free-running Galois LFSR; an all-zero seed is replaced by 1 so it never locks up.
module esm_lfsr
  import esm_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_POLY[WIDTH-1:0] : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED_NZ;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/esm_cand_selector.sv
// Compacts a candidate bitmap into an index table one bit per cycle, then
// picks one slot (random / round-robin / lowest) and presents it on a valid/ready port.
module esm_cand_selector
  import esm_pkg::*;
#(
  parameter int          BS    = 16,
  parameter int          RND_W = 16,
  parameter logic [31:0] SEED  = 32'hACE1_0001
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   cand_valid,
  output logic                   cand_ready,
  input  logic [BS-1:0]          cand_list,
  output logic                   sel_valid,
  input  logic                   sel_ready,
  output logic [$clog2(BS)-1:0]  sel_index,
  output logic [$clog2(BS+1)-1:0] sel_count,
  output logic                   sel_empty
);

  localparam int IW = $clog2(BS);
  localparam int CW = $clog2(BS+1);
  localparam int PW = RND_W + CW;

  logic [31:0] lfsr;

  esm_lfsr #(.WIDTH(32), .SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr)
  );

  generate
    if (RND_W < 32) begin : g_unused
      logic unused_lfsr;
      assign unused_lfsr = ^lfsr[31:RND_W];
    end
  endgenerate

  state_t                 state_q, state_d;
  sel_mode_t              mode_q, mode_d;
  logic [BS-1:0]          list_q, list_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [BS-1:0][IW-1:0]  tbl_q, tbl_d;
  logic [IW-1:0]          rr_last_q, rr_last_d;
  logic [IW-1:0]          rr_hit_q, rr_hit_d;
  logic                   rr_found_q, rr_found_d;
  logic                   cand_ready_q, cand_ready_d;
  logic                   sel_valid_q, sel_valid_d;
  logic [IW-1:0]          sel_index_q, sel_index_d;
  logic [CW-1:0]          sel_count_q, sel_count_d;
  logic                   sel_empty_q, sel_empty_d;

  logic [PW-1:0]          prod;
  logic [IW-1:0]          rnd_k;
  logic [IW-1:0]          pick;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    list_d       = list_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    tbl_d        = tbl_q;
    rr_last_d    = rr_last_q;
    rr_hit_d     = rr_hit_q;
    rr_found_d   = rr_found_q;
    cand_ready_d = cand_ready_q;
    sel_valid_d  = sel_valid_q;
    sel_index_d  = sel_index_q;
    sel_count_d  = sel_count_q;
    sel_empty_d  = sel_empty_q;

    // Full-width product keeps k strictly below count, including count==BS
    prod  = PW'(lfsr[RND_W-1:0]) * PW'(count_q);
    rnd_k = IW'(prod >> RND_W);

    case (mode_q)
      RANDOM:      pick = tbl_q[rnd_k];
      ROUND_ROBIN: pick = rr_found_q ? rr_hit_q : tbl_q[0];
      default:     pick = tbl_q[0];
    endcase

    case (state_q)
      IDLE: begin
        if (cand_valid) begin
          list_d       = cand_list;
          mode_d       = (mode == 2'd3) ? LOWEST : sel_mode_t'(mode);
          count_d      = '0;
          ptr_d        = '0;
          rr_found_d   = 1'b0;
          cand_ready_d = 1'b0;
          state_d      = BUILD;
        end
      end
      BUILD: begin
        if (list_q[ptr_q]) begin
          tbl_d[count_q[IW-1:0]] = ptr_q;
          count_d                = count_q + CW'(1);
          if (!rr_found_q && (ptr_q > rr_last_q)) begin
            rr_found_d = 1'b1;
            rr_hit_d   = ptr_q;
          end
        end
        ptr_d = ptr_q + IW'(1);
        if (ptr_q == IW'(BS-1)) state_d = SELECT;
      end
      SELECT: begin
        sel_valid_d = 1'b1;
        sel_count_d = count_q;
        sel_empty_d = (count_q == '0);
        sel_index_d = (count_q == '0) ? '0 : pick;
        if (mode_q == ROUND_ROBIN && count_q != '0) rr_last_d = pick;
        state_d = OUT;
      end
      default: begin
        if (sel_ready) begin
          sel_valid_d  = 1'b0;
          cand_ready_d = 1'b1;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= LOWEST;
      list_q       <= '0;
      ptr_q        <= '0;
      count_q      <= '0;
      tbl_q        <= '0;
      rr_last_q    <= IW'(BS-1);
      rr_hit_q     <= '0;
      rr_found_q   <= 1'b0;
      cand_ready_q <= 1'b1;
      sel_valid_q  <= 1'b0;
      sel_index_q  <= '0;
      sel_count_q  <= '0;
      sel_empty_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      list_q       <= list_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      tbl_q        <= tbl_d;
      rr_last_q    <= rr_last_d;
      rr_hit_q     <= rr_hit_d;
      rr_found_q   <= rr_found_d;
      cand_ready_q <= cand_ready_d;
      sel_valid_q  <= sel_valid_d;
      sel_index_q  <= sel_index_d;
      sel_count_q  <= sel_count_d;
      sel_empty_q  <= sel_empty_d;
    end
  end

  assign cand_ready = cand_ready_q;
  assign sel_valid  = sel_valid_q;
  assign sel_index  = sel_index_q;
  assign sel_count  = sel_count_q;
  assign sel_empty  = sel_empty_q;

endmodule

// File: tb/tb_esm_cand_selector.sv
// Directed bench for esm_cand_selector with a bitmap-level reference model.
module tb_esm_cand_selector;

  localparam int          BS   = 16;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk, rst;
  logic [1:0]  mode;
  logic        cand_valid, cand_ready;
  logic [15:0] cand_list;
  logic        sel_valid, sel_ready;
  logic [3:0]  sel_index;
  logic [4:0]  sel_count;
  logic        sel_empty;

  int total = 0;
  int bad   = 0;

  esm_cand_selector #(.BS(BS), .RND_W(16), .SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_list  (cand_list),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_index  (sel_index),
    .sel_count  (sel_count),
    .sel_empty  (sel_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference pick straight from the bitmap: list the set bits, then choose.
  function automatic void model_pick(input logic [1:0] m, input logic [15:0] l,
                                     input logic [31:0] lf, input int rr,
                                     output int idx, output int cnt, output int nrr);
    int set[$];
    int k;
    for (int i = 0; i < BS; i++) if (l[i]) set.push_back(i);
    cnt = set.size();
    nrr = rr;
    idx = 0;
    if (cnt != 0) begin
      case (m)
        2'd0: begin
          k   = int'((longint'(lf[15:0]) * longint'(cnt)) >>> 16);
          idx = set[k];
        end
        2'd1: begin
          idx = set[0];
          for (int j = cnt - 1; j >= 0; j--) if (set[j] > rr) idx = set[j];
          nrr = idx;
        end
        default: idx = set[0];
      endcase
    end
  endfunction

  // Model: phase 0 idle, 1 scanning (BS cycles), 2 pick, 3 result presented.
  int          ph, ctr, m_rr, e_idx, e_cnt;
  logic [31:0] m_lfsr;
  logic [15:0] m_list;
  logic [1:0]  m_mode;
  int          p_idx, p_cnt, p_rr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; ctr <= 0; m_lfsr <= SEED; m_rr <= BS - 1;
      e_idx <= 0; e_cnt <= 0;
    end else begin
      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'd0);
      case (ph)
        0: if (cand_valid) begin
             m_list <= cand_list; m_mode <= mode; ctr <= 0; ph <= 1;
           end
        1: begin
             ctr <= ctr + 1;
             if (ctr == BS - 1) ph <= 2;
           end
        2: begin
             model_pick(m_mode, m_list, m_lfsr, m_rr, p_idx, p_cnt, p_rr);
             e_idx <= p_idx; e_cnt <= p_cnt; m_rr <= p_rr; ph <= 3;
           end
        default: if (sel_ready) ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_cand_ready", int'(cand_ready), int'(ph == 0));
      chk("cyc_sel_valid", int'(sel_valid), int'(ph == 3));
      if (ph == 3) begin
        chk("cyc_sel_index", int'(sel_index), e_idx);
        chk("cyc_sel_count", int'(sel_count), e_cnt);
        chk("cyc_sel_empty", int'(sel_empty), int'(e_cnt == 0));
      end
    end
  end

  task automatic req(input logic [1:0] m, input logic [15:0] l, input int stall,
                     output int idx, output int cnt, output int emp, output int lat);
    int n;
    mode = m; cand_list = l; cand_valid = 1'b1;
    n = 0;
    while (!cand_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cand_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cand_valid = 1'b0;
    cand_list  = 16'($urandom);
    mode       = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!sel_valid && lat < 40);
    if (!sel_valid) chk("result_timeout", 0, 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("bp_cand_ready", int'(cand_ready), 0);
      chk("bp_sel_valid", int'(sel_valid), 1);
    end
    idx = sel_index; cnt = sel_count; emp = sel_empty;
    @(posedge clk); #1 sel_ready = 1'b1;
    @(posedge clk); #1 sel_ready = 1'b0;
  endtask

  int idx, cnt, emp, lat;
  int hist[BS];
  int rr_exp[5] = '{0, 2, 8, 10, 0};

  initial begin
    rst = 1'b1; mode = 2'd0; cand_valid = 1'b0; cand_list = '0; sel_ready = 1'b0;
    #1;
    chk("rst_cand_ready", int'(cand_ready), 1);
    chk("rst_sel_valid", int'(sel_valid), 0);
    chk("rst_sel_index", int'(sel_index), 0);
    chk("rst_sel_count", int'(sel_count), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // LOWEST, single candidate
    req(2'd2, 16'h0010, 0, idx, cnt, emp, lat);
    chk("low_lat", lat, 18);
    chk("low_index", idx, 4);
    chk("low_count", cnt, 1);
    chk("low_empty", emp, 0);

    // asynchronous reset in the middle of a cycle
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_cand_ready", int'(cand_ready), 1);
    chk("async_sel_valid", int'(sel_valid), 0);
    chk("async_sel_index", int'(sel_index), 0);
    @(posedge clk); #1 rst = 1'b0;

    // no candidates
    req(2'd1, 16'h0000, 0, idx, cnt, emp, lat);
    chk("empty_lat", lat, 18);
    chk("empty_flag", emp, 1);
    chk("empty_count", cnt, 0);
    chk("empty_index", idx, 0);

    // round-robin sequence, back-to-back
    for (int r = 0; r < 5; r++) begin
      req(2'd1, 16'h0505, 0, idx, cnt, emp, lat);
      chk($sformatf("rr_index_%0d", r), idx, rr_exp[r]);
      chk($sformatf("rr_count_%0d", r), cnt, 4);
    end

    // reserved mode acts as LOWEST; full bitmap gives count==BS
    req(2'd3, 16'h0C00, 0, idx, cnt, emp, lat);
    chk("mode3_index", idx, 10);
    req(2'd2, 16'hFFFF, 0, idx, cnt, emp, lat);
    chk("full_count", cnt, 16);
    chk("full_index", idx, 0);

    // backpressure: result held while sel_ready is low
    req(2'd2, 16'h0300, 5, idx, cnt, emp, lat);
    chk("bp_index", idx, 8);
    chk("bp_count", cnt, 2);

    // random distribution over a full bitmap
    for (int i = 0; i < BS; i++) hist[i] = 0;
    for (int r = 0; r < 1600; r++) begin
      req(2'd0, 16'hFFFF, 0, idx, cnt, emp, lat);
      chk("rnd_count", cnt, 16);
      chk("rnd_range", int'(idx < BS), 1);
      if (idx >= 0 && idx < BS) hist[idx]++;
    end
    for (int i = 0; i < BS; i++)
      chk($sformatf("rnd_hist_%0d", i), int'(hist[i] >= 60 && hist[i] <= 140), 1);

    // reset during BUILD cycle 7, then a clean request
    mode = 2'd2; cand_list = 16'h00F0; cand_valid = 1'b1;
    @(posedge clk); #1 cand_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_cand_ready", int'(cand_ready), 1);
    chk("midrst_sel_valid", int'(sel_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    req(2'd2, 16'h8000, 0, idx, cnt, emp, lat);
    chk("post_rst_lat", lat, 18);
    chk("post_rst_index", idx, 15);
    chk("post_rst_count", cnt, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
